// File: rtl/router_pkg.sv
// Shared types and constants for the router datapath blocks.
package router_pkg;

    localparam int unsigned ADDR_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } wag_state_e;

endpackage

// File: rtl/window_addr_generator.sv
// Expands each output-pixel coordinate into the K x K input-SRAM address window,
// row-major with ky innermost, using incremental address updates.
module window_addr_generator
    import router_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_en,
    input  logic                  i_reg_clear,
    input  logic [ADDR_WIDTH-1:0] i_i_size,
    input  logic [ADDR_WIDTH-1:0] i_k_size,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    input  logic [ADDR_WIDTH-1:0] i_o_x,
    input  logic [ADDR_WIDTH-1:0] i_o_y,
    input  logic                  i_coord_valid,
    input  logic                  i_coord_done,
    output logic                  o_coord_ready,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_addr_valid,
    input  logic                  i_addr_ready,
    output logic                  o_window_last,
    output logic                  o_done
);

    wag_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [ADDR_WIDTH-1:0] kx_q, kx_d;
    logic [ADDR_WIDTH-1:0] ky_q, ky_d;
    logic                  addr_valid_q, addr_valid_d;
    logic                  done_q, done_d;

    logic [ADDR_WIDTH-1:0] k_last;
    logic [ADDR_WIDTH-1:0] x_times_i;
    logic [ADDR_WIDTH-1:0] capture_addr;
    logic [ADDR_WIDTH-1:0] next_row;
    logic                  accept;

    // A kernel size of 0 is treated as 1, so the last index is 0 either way.
    assign k_last       = (i_k_size == '0) ? '0 : i_k_size - ADDR_WIDTH'(1);
    assign x_times_i    = i_o_x * i_i_size;
    assign capture_addr = i_start_addr + x_times_i + i_o_y;
    assign next_row     = row_base_q + i_i_size;
    assign accept       = i_addr_ready && i_en;

    // Held low while in reset or clear so the generator never advances on a lost capture.
    assign o_coord_ready = i_nrst && i_en && !i_reg_clear && (state_q == IDLE);
    assign o_addr        = addr_q;
    assign o_addr_valid  = addr_valid_q;
    assign o_window_last = addr_valid_q && (kx_q == k_last) && (ky_q == k_last);
    assign o_done        = done_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        row_base_d   = row_base_q;
        kx_d         = kx_q;
        ky_d         = ky_q;
        addr_valid_d = addr_valid_q;
        done_d       = done_q;

        if (i_reg_clear) begin
            state_d      = IDLE;
            addr_d       = '0;
            row_base_d   = '0;
            kx_d         = '0;
            ky_d         = '0;
            addr_valid_d = 1'b0;
            done_d       = 1'b0;
        end else if (i_en) begin
            case (state_q)
                IDLE: begin
                    if (i_coord_valid) begin
                        addr_d       = capture_addr;
                        row_base_d   = capture_addr;
                        kx_d         = '0;
                        ky_d         = '0;
                        addr_valid_d = 1'b1;
                        state_d      = EMIT;
                    end else if (i_coord_done) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
                EMIT: begin
                    if (accept) begin
                        if (ky_q < k_last) begin
                            ky_d   = ky_q + ADDR_WIDTH'(1);
                            addr_d = addr_q + ADDR_WIDTH'(1);
                        end else if (kx_q < k_last) begin
                            ky_d       = '0;
                            kx_d       = kx_q + ADDR_WIDTH'(1);
                            row_base_d = next_row;
                            addr_d     = next_row;
                        end else begin
                            addr_valid_d = 1'b0;
                            state_d      = IDLE;
                        end
                    end
                end
                DONE: begin
                    done_d       = 1'b1;
                    addr_valid_d = 1'b0;
                end
                default: begin
                    state_d      = IDLE;
                    addr_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            row_base_q   <= '0;
            kx_q         <= '0;
            ky_q         <= '0;
            addr_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            row_base_q   <= row_base_d;
            kx_q         <= kx_d;
            ky_q         <= ky_d;
            addr_valid_q <= addr_valid_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_window_addr_generator.sv
// Directed bench for window_addr_generator with a simple coordinate-generator model.
module tb_window_addr_generator;

    logic       clk = 1'b0;
    logic       i_nrst, i_en, i_reg_clear;
    logic [7:0] i_i_size, i_k_size, i_start_addr, i_o_x, i_o_y;
    logic       i_coord_valid, i_coord_done, i_addr_ready;
    logic       o_coord_ready, o_addr_valid, o_window_last, o_done;
    logic [7:0] o_addr;

    int checks   = 0;
    int failures = 0;

    logic [7:0] cx[$], cy[$], exp_addr[$];
    logic       exp_last[$];
    int rdy_lo_start, rdy_lo_len, en_lo_start, en_lo_len;

    always #5 clk = ~clk;

    window_addr_generator #(.ADDR_WIDTH(8)) dut (
        .i_clk        (clk),
        .i_nrst       (i_nrst),
        .i_en         (i_en),
        .i_reg_clear  (i_reg_clear),
        .i_i_size     (i_i_size),
        .i_k_size     (i_k_size),
        .i_start_addr (i_start_addr),
        .i_o_x        (i_o_x),
        .i_o_y        (i_o_y),
        .i_coord_valid(i_coord_valid),
        .i_coord_done (i_coord_done),
        .o_coord_ready(o_coord_ready),
        .o_addr       (o_addr),
        .o_addr_valid (o_addr_valid),
        .i_addr_ready (i_addr_ready),
        .o_window_last(o_window_last),
        .o_done       (o_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        i_coord_valid = 1'b0;
        i_coord_done  = 1'b0;
        i_reg_clear   = 1'b1;
        @(negedge clk);
        i_reg_clear = 1'b0;
        #1;
    endtask

    // Drives the coordinate list like the upstream generator and collects the address stream.
    task automatic run(input string name, input int exp_done_cycle);
        int         idx = 0;
        int         done_cycle = -1;
        int         last_hs = -1;
        bit         prev_stall = 0;
        logic [7:0] hold_addr = '0;
        logic [7:0] got_a[$];
        logic       got_l[$];
        bit         stall;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            i_addr_ready  = !(cyc >= rdy_lo_start && cyc < rdy_lo_start + rdy_lo_len);
            i_en          = !(cyc >= en_lo_start && cyc < en_lo_start + en_lo_len);
            i_coord_valid = (idx < cx.size());
            i_o_x         = i_coord_valid ? cx[idx] : 8'h00;
            i_o_y         = i_coord_valid ? cy[idx] : 8'h00;
            i_coord_done  = (idx == cx.size());
            #1;
            if (o_done) begin
                done_cycle = cyc;
                break;
            end
            stall = !i_addr_ready || !i_en;
            if (stall) begin
                chk({name, " stall_valid"}, o_addr_valid, 1'b1);
                chk({name, " stall_coord_ready"}, o_coord_ready, 1'b0);
                if (prev_stall) chk({name, " stall_hold"}, o_addr, hold_addr);
                hold_addr = o_addr;
            end
            prev_stall = stall;
            if (o_addr_valid && i_addr_ready && i_en) begin
                got_a.push_back(o_addr);
                got_l.push_back(o_window_last);
                last_hs = cyc;
            end
            if (o_coord_ready && i_coord_valid) idx++;
        end
        chk({name, " done_reached"}, (done_cycle >= 0), 1'b1);
        chk({name, " done_cycle"}, done_cycle, exp_done_cycle);
        chk({name, " done_after_last_hs"}, done_cycle - last_hs, 2);
        chk({name, " count"}, got_a.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < got_a.size(); i++) begin
            chk($sformatf("%s addr[%0d]", name, i), got_a[i], exp_addr[i]);
            chk($sformatf("%s last[%0d]", name, i), got_l[i], exp_last[i]);
        end
        rdy_lo_start = -1; rdy_lo_len = 0; en_lo_start = -1; en_lo_len = 0;
        i_en = 1'b1;
        i_addr_ready = 1'b1;
    endtask

    task automatic check_zero(input string name);
        chk({name, " addr"}, o_addr, 8'h00);
        chk({name, " valid"}, o_addr_valid, 1'b0);
        chk({name, " last"}, o_window_last, 1'b0);
        chk({name, " done"}, o_done, 1'b0);
    endtask

    task automatic load_k3();
        i_i_size = 8'd5; i_k_size = 8'd3; i_start_addr = 8'h00;
        cx = '{8'd1}; cy = '{8'd2};
        exp_addr = '{8'h07, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h0E, 8'h11, 8'h12, 8'h13};
        exp_last = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    endtask

    initial begin
        rdy_lo_start = -1; rdy_lo_len = 0; en_lo_start = -1; en_lo_len = 0;
        i_nrst = 1'b0; i_en = 1'b1; i_reg_clear = 1'b0;
        i_i_size = 8'd4; i_k_size = 8'd2; i_start_addr = 8'h10;
        i_o_x = 8'h00; i_o_y = 8'h00;
        i_coord_valid = 1'b1; i_coord_done = 1'b0; i_addr_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset");
        chk("reset coord_ready", o_coord_ready, 1'b0);
        i_coord_valid = 1'b0;
        i_nrst = 1'b1;

        // Basic sweep: 4 windows of 4 addresses plus one bubble each.
        cx = '{8'd0, 8'd0, 8'd2, 8'd2}; cy = '{8'd0, 8'd2, 8'd0, 8'd2};
        exp_addr = '{8'h10, 8'h11, 8'h14, 8'h15, 8'h12, 8'h13, 8'h16, 8'h17,
                     8'h18, 8'h19, 8'h1C, 8'h1D, 8'h1A, 8'h1B, 8'h1E, 8'h1F};
        exp_last = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
        run("sweep", 21);
        clear_pulse();
        check_zero("clear");
        chk("clear coord_ready", o_coord_ready, 1'b1);

        load_k3();
        run("k3", 11);
        clear_pulse();

        load_k3();
        rdy_lo_start = 3; rdy_lo_len = 3;
        run("backpressure", 14);
        clear_pulse();

        load_k3();
        en_lo_start = 4; en_lo_len = 5;
        run("enable", 16);
        clear_pulse();

        i_i_size = 8'd4; i_k_size = 8'd2; i_start_addr = 8'hFE;
        cx = '{8'd0}; cy = '{8'd0};
        exp_addr = '{8'hFE, 8'hFF, 8'h02, 8'h03};
        exp_last = '{0, 0, 0, 1};
        run("wrap", 6);
        clear_pulse();

        i_i_size = 8'd4; i_k_size = 8'd0; i_start_addr = 8'h00;
        cx = '{8'd1}; cy = '{8'd1};
        exp_addr = '{8'h05};
        exp_last = '{1};
        run("k0", 3);
        clear_pulse();

        // Asynchronous reset in the middle of a window.
        load_k3();
        @(negedge clk);
        i_o_x = 8'd1; i_o_y = 8'd2; i_coord_valid = 1'b1;
        @(negedge clk);
        i_coord_valid = 1'b0; i_coord_done = 1'b1;
        @(negedge clk);
        #1;
        chk("pre_reset valid", o_addr_valid, 1'b1);
        chk("pre_reset addr", o_addr, 8'h08);
        #2;
        i_nrst = 1'b0;
        #1;
        check_zero("async_reset");
        chk("async_reset coord_ready", o_coord_ready, 1'b0);
        @(negedge clk);
        i_coord_done = 1'b0;
        i_nrst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/window_addr_generator.md
# window_addr_generator

Consumes output-pixel coordinates from the router's `coordinate_generator` and expands each one into the K×K stream of input-SRAM addresses covering that convolution window. The address order is row-major: ky is the inner loop and kx is the outer loop. It sits between the coordinate generator, whose `i_en` it drives via `o_coord_ready`, and the input-buffer read port, which accepts addresses through a valid/ready handshake. Addresses are computed incrementally, so the datapath needs no per-address multiplier.

## Interface
- `ADDR_WIDTH`, default 8: width of all address, size and coordinate fields.
- `i_clk`  in  1  clock; the block uses one clock.
- `i_nrst`  in  1  reset, asynchronous, active-low.
- `i_en`  in  1  global enable; when low, all state is frozen and `o_coord_ready` is 0.
- `i_reg_clear`  in  1  synchronous clear to reset values; takes priority over everything except reset.
- `i_i_size`  in  ADDR_WIDTH  input feature-map width I (row pitch).
- `i_k_size`  in  ADDR_WIDTH  kernel size K; 0 is illegal and behaves as 1.
- `i_start_addr`  in  ADDR_WIDTH  base address of the input map.
- `i_o_x`  in  ADDR_WIDTH  coordinate row, already multiplied by stride.
- `i_o_y`  in  ADDR_WIDTH  coordinate column, already multiplied by stride.
- `i_coord_valid`  in  1  coordinate valid.
- `i_coord_done`  in  1  coordinate generator finished.
- `o_coord_ready`  out  1  consume coordinate; wired to the generator's `i_en`.
- `o_addr`  out  ADDR_WIDTH  input-buffer read address.
- `o_addr_valid`  out  1  `o_addr` is valid.
- `i_addr_ready`  in  1  consumer accepts `o_addr`.
- `o_window_last`  out  1  qualifies the final address of a window.
- `o_done`  out  1  all windows emitted; sticky.

## Operation
- **FSM states:** IDLE, EMIT, DONE.
- **IDLE**
  - `o_coord_ready = i_en`.
  - When `i_coord_valid && o_coord_ready`:
    - capture `o_addr <= i_start_addr + i_o_x*i_i_size + i_o_y`;
    - set `row_base <= o_addr` (same value);
    - clear the counters: `ky <= 0`, `kx <= 0`;
    - go to EMIT.
  - Otherwise, if `i_coord_done && !i_coord_valid`, go to DONE.
- **EMIT**
  - `o_addr_valid = 1` and `o_coord_ready = 0`.
  - An address is accepted on a cycle where `i_addr_ready && i_en`. On acceptance:
    - if `ky < K-1`: `ky++`, `o_addr <= o_addr + 1`;
    - else if `kx < K-1`: `ky <= 0`, `kx++`, `row_base <= row_base + I`, `o_addr <= row_base + I`;
    - else this is the last address of the window: return to IDLE.
  - `o_window_last = (kx==K-1 && ky==K-1) && o_addr_valid`.
- **DONE**
  - `o_done = 1`, `o_addr_valid = 0`, `o_coord_ready = 0`.
  - The block stays in DONE until `i_reg_clear` or reset.
- **Arithmetic:** all address arithmetic is modulo 2^ADDR_WIDTH, so wrap-around is silent. The product `x*I` is truncated to ADDR_WIDTH.
- **Late done:** if `i_coord_done` rises during EMIT, the current window completes first. DONE is entered from IDLE only.
- **Backpressure:** while `i_addr_ready` is low, `o_addr`, `o_addr_valid` and `o_window_last` hold stable.
- **Parameter inputs** (`i_i_size`, `i_k_size`, `i_start_addr`) must be stable from clear until `o_done`. Changing them mid-window is undefined.

## Timing
- **Reset / clear values:** state=IDLE, `o_addr=0`, `o_addr_valid=0`, `o_window_last=0`, `o_coord_ready=0` (during reset), `o_done=0`; all internal counters 0.
- **Capture latency:** coordinate capture at edge N; the first address is valid in cycle N+1.
- **Throughput:** with `i_addr_ready` held high, one address per cycle, K² cycles per window, plus one IDLE bubble cycle per window.
- **Handshake overlap:** the coordinate generator advances on the same edge as the capture. Its next valid coordinate is already present when the FSM returns to IDLE.
- **Completion:** the generator raises `done` on the edge that captures the last coordinate. `o_done` rises one cycle after the last window's final handshake (the IDLE→DONE transition).
- **Reset mid-window:** outputs go to reset values asynchronously; no partial window resumes.

## Structure
- **Package `router_pkg`:** holds the `wag_state_e` enum (IDLE/EMIT/DONE) and a shared `ADDR_WIDTH_DEFAULT` constant.
- **Sub-modules:** none required. The K×K (kx, ky) counter pair is simple enough to remain inline.
- **Multiplier:** the single multiplier `x*I` is used only on capture and may be pipelined later without interface change.

## Test plan
- **Basic sweep.** I=4, K=2, O=2, S=2, start=0x10, ready=1, generator attached.
  - Address stream: 10,11,14,15 | 12,13,16,17 | 18,19,1C,1D | 1A,1B,1E,1F.
  - `o_window_last` asserted on 15, 17, 1D and 1F.
  - `o_done` asserted after 16 addresses plus 4 bubble cycles.
- **K=3, I=5, direct stimulus.** Coordinate (1,2), start=0 → 07,08,09,0C,0D,0E,11,12,13; `o_window_last` on 0x13.
- **Backpressure.** Drop `i_addr_ready` for 3 cycles mid-window:
  - `o_addr` holds its value and `o_addr_valid` stays 1;
  - no address is skipped or duplicated;
  - `o_coord_ready` stays 0.
- **Wrap-around.** ADDR_WIDTH=8, start=0xFE, I=4, K=2, coordinate (0,0) → FE,FF,02,03.
- **Late done, clear, and reset.**
  - Assert `i_coord_done` during EMIT: the window completes, then DONE is entered.
  - `i_reg_clear` in DONE → IDLE, with all outputs at 0.
  - Assert `i_nrst` low mid-window → outputs go to 0 asynchronously.
- **Enable gating.** `i_en`=0 for 5 cycles mid-window: state, address and counters freeze, and `o_coord_ready` stays 0. The stream resumes identically once `i_en` returns high.
